win_div_16_8: RTL and testbench



---
 rtl/win_arith_pkg.sv | 23 ++
 rtl/win_div_step.sv | 27 ++
 rtl/win_div_16_8.sv | 168 ++++++++++++++++
 tb/tb_win_div_16_8.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/win_arith_pkg.sv
// Shared arithmetic definitions for the Winograd/LeNet datapath: state encoding,
// default operand widths and sign-magnitude helpers.
package win_arith_pkg;

    localparam int unsigned W16 = 16;
    localparam int unsigned W8  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } div_state_e;

    // Sign bit of a sign-magnitude value; a zero magnitude always yields +0.
    function automatic logic sm_fix_sign(input logic sign, input logic mag_nz);
        return sign & mag_nz;
    endfunction

endpackage

// File: rtl/win_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep or restore the partial remainder.
module win_div_step
    import win_arith_pkg::*;
#(
    parameter int unsigned DW_B = W8
) (
    input  logic [DW_B-2:0] prem_i,
    input  logic            bit_i,
    input  logic [DW_B-2:0] dvs_i,
    output logic [DW_B-2:0] rem_o_c,
    output logic            qbit_o_c
);

    logic [DW_B-1:0] shifted;
    logic [DW_B-1:0] diff;

    // Shifted remainder is below twice the divisor, so the MSB of the
    // DW_B-bit difference is a reliable borrow flag.
    always_comb begin
        shifted  = {prem_i, bit_i};
        diff     = shifted - {1'b0, dvs_i};
        qbit_o_c = ~diff[DW_B-1];
        rem_o_c  = qbit_o_c ? diff[DW_B-2:0] : shifted[DW_B-2:0];
    end

endmodule

// File: rtl/win_div_16_8.sv
// Sequential sign-magnitude restoring divider, one quotient bit per cycle.
// WIN_DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module win_div_16_8
    import win_arith_pkg::*;
#(
    parameter int unsigned DW_A = W16,
    parameter int unsigned DW_B = W8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_A-1:0] div_a,
    input  logic [DW_B-1:0] div_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_A-1:0] quot,
    output logic [DW_B-1:0] rem,
    output logic            div_err
);

    localparam int unsigned MA = DW_A - 1;
    localparam int unsigned MB = DW_B - 1;
    localparam int unsigned CW = $clog2(DW_A);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MA-1:0]   wq_q, wq_d;
    logic [MB-1:0]   prem_q, prem_d;
    logic [MB-1:0]   dvs_q, dvs_d;
    logic            sign_q, sign_d;
    logic            rsign_q, rsign_d;
    logic [DW_A-1:0] quot_q, quot_d;
    logic [DW_B-1:0] rem_q, rem_d;
    logic            err_q, err_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [MA-1:0]   a_mag;
    logic [MB-1:0]   b_mag;
    logic [MB-1:0]   step_rem;
    logic            step_qbit;

    assign a_mag = div_a[MA-1:0];
    assign b_mag = div_b[MB-1:0];

    win_div_step #(.DW_B(DW_B)) u_step (
        .prem_i   (prem_q),
        .bit_i    (wq_q[MA-1]),
        .dvs_i    (dvs_q),
        .rem_o_c  (step_rem),
        .qbit_o_c (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wq_d        = wq_q;
        prem_d      = prem_q;
        dvs_d       = dvs_q;
        sign_d      = sign_q;
        rsign_d     = rsign_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    wq_d       = a_mag;
                    dvs_d      = b_mag;
                    prem_d     = '0;
                    cnt_d      = '0;
                    // A -0 operand counts as +0 for sign purposes too.
                    rsign_d    = sm_fix_sign(div_a[DW_A-1], |a_mag);
                    sign_d     = rsign_d ^ sm_fix_sign(div_b[DW_B-1], |b_mag);
                    in_ready_d = 1'b0;
                    if (b_mag == '0) begin
                        state_d = DONE;
                        quot_d  = {sign_d, {MA{1'b1}}};
                        rem_d   = '0;
                        err_d   = 1'b1;
                    end
`ifdef WIN_DIV_EARLY_EXIT_EN
                    else if (a_mag < MA'(b_mag)) begin
                        state_d = DONE;
                        quot_d  = '0;
                        rem_d   = {rsign_d, MB'(a_mag)};
                        err_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                prem_d = step_rem;
                wq_d   = {wq_q[MA-2:0], step_qbit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(MA - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quot_d      = {sm_fix_sign(sign_q, |wq_d), wq_d};
                    rem_d       = {sm_fix_sign(rsign_q, |step_rem), step_rem};
                    err_d       = 1'b0;
                end
            end

            DONE: begin
                // Single-cycle paths enter DONE before raising out_valid.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wq_q        <= '0;
            prem_q      <= '0;
            dvs_q       <= '0;
            sign_q      <= 1'b0;
            rsign_q     <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wq_q        <= wq_d;
            prem_q      <= prem_d;
            dvs_q       <= dvs_d;
            sign_q      <= sign_d;
            rsign_q     <= rsign_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div_err   = err_q;

endmodule

// File: tb/tb_win_div_16_8.sv
// Scoreboard bench for win_div_16_8: directed table plus randomized operands
// checked against an integer-arithmetic reference model.
module tb_win_div_16_8;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

`ifdef WIN_DIV_EARLY_EXIT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] div_a = '0;
    logic [7:0]  div_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic        div_err;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   force_hold = 0;
    exp_t sbq[$];

    bit          seen = 1'b0;
    bit          hs_pend = 1'b0;
    logic [15:0] hq;
    logic [7:0]  hr;
    logic        he;

    win_div_16_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_a     (div_a),
        .div_b     (div_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_latency(input logic [15:0] a, input logic [7:0] b);
        int unsigned am;
        int unsigned bm;
        am = 32'(a[14:0]);
        bm = 32'(b[6:0]);
        if (bm == 0) return 1;
        if (EARLY_EN && am < bm) return 1;
        return 15;
    endfunction

    // Reference: plain integer division on magnitudes, signs from operand signs.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t        m;
        int unsigned am, bm, qm, rm;
        bit          sa, sbit, s;
        am   = 32'(a[14:0]);
        bm   = 32'(b[6:0]);
        sa   = a[15] && (am != 0);
        sbit = b[7] && (bm != 0);
        s    = sa ^ sbit;
        if (bm == 0) begin
            m.q = {s, 15'h7FFF};
            m.r = 8'h00;
            m.e = 1'b1;
        end else begin
            qm  = am / bm;
            rm  = am % bm;
            m.q = {s && (qm != 0), 15'(qm)};
            m.r = {sa && (rm != 0), 7'(rm)};
            m.e = 1'b0;
        end
        m.lat = exp_latency(a, b);
        m.acc = 0;
        return m;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] q, input logic [7:0] r, input logic e);
        exp_t x;
        int   w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1 within 300 cycles");
            return;
        end
        div_a    = a;
        div_b    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        x.q   = q;
        x.r   = r;
        x.e   = e;
        x.lat = exp_latency(a, b);
        x.acc = cyc;
        sbq.push_back(x);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_quot"}, 32'(quot), 32'd0);
        chk({tag, "_rem"}, 32'(rem), 32'd0);
        chk({tag, "_div_err"}, 32'(div_err), 32'd0);
    endtask

    // Monitor: pop on first presentation, then verify hold and release behaviour.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen      = 1'b0;
            hs_pend   = 1'b0;
            out_ready = 1'b0;
        end else begin
            if (seen && hs_pend) begin
                chk("release_out_valid", 32'(out_valid), 32'd0);
                chk("release_in_ready", 32'(in_ready), 32'd1);
                seen    = 1'b0;
                hs_pend = 1'b0;
            end else if (seen) begin
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_quot", 32'(quot), 32'(hq));
                chk("hold_rem", 32'(rem), 32'(hr));
                chk("hold_div_err", 32'(div_err), 32'(he));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end else if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got quot 0x%0h with empty scoreboard", quot);
                end else begin
                    exp_t x;
                    x = sbq.pop_front();
                    chk("quot", 32'(quot), 32'(x.q));
                    chk("rem", 32'(rem), 32'(x.r));
                    chk("div_err", 32'(div_err), 32'(x.e));
                    chk("latency", 32'(cyc - x.acc), 32'(x.lat));
                    chk("busy_in_ready", 32'(in_ready), 32'd0);
                end
                hq   = quot;
                hr   = rem;
                he   = div_err;
                seen = 1'b1;
            end
            if (seen) begin
                if (force_hold > 0) begin
                    out_ready = 1'b0;
                    force_hold--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                hs_pend = out_ready;
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    logic [15:0] d_a [7] = '{16'h0064, 16'h8064, 16'h0064, 16'h7FFF, 16'h8005, 16'h8010, 16'h8010};
    logic [7:0]  d_b [7] = '{8'h07, 8'h07, 8'h87, 8'h01, 8'h85, 8'h00, 8'h80};
    logic [15:0] d_q [7] = '{16'h000E, 16'h800E, 16'h800E, 16'h7FFF, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic [7:0]  d_r [7] = '{8'h02, 8'h82, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    logic        d_e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        exp_t        m;
        int          w;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First result is held off for 10 cycles.
        force_hold = 10;
        for (int i = 0; i < 7; i++) begin
            issue(d_a[i], d_b[i], d_q[i], d_r[i], d_e[i]);
        end

        // Abort in the middle of a calculation, then run a fresh operation.
        issue(16'h1234, 8'h05, 16'h03A4, 8'h00, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0003, 8'h05, 16'h0000, 8'h03, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 5))
                0: rb[6:0] = 7'h00;
                1: ra[14:7] = 8'h00;
                2: ra[14:0] = 15'h0000;
                default: ;
            endcase
            m = model(ra, rb);
            issue(ra, rb, m.q, m.r, m.e);
        end

        w = 0;
        while ((sbq.size() != 0 || seen) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0 || seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
